onchip_mem_stream_reader: RTL and testbench

Avalon-MM read master that drains a contiguous block of words from the 32-bit single-port on-chip memory and presents them, in address order, on an Avalon-ST source with ready/valid backpressure. It sits between the memory's slave port and stream consumers, such as video overlay or pose-data logic, so the CPU only programs a base address and word count and then waits for `done`. Reads are pipelined against the memory's fixed 1-cycle read latency and are gated by a small output FIFO, so backpressure never loses data.

---
 rtl/onchip_mem_stream_reader_if.sv | 46 ++++
 rtl/onchip_mem_stream_reader.sv | 159 +++++++++++++++
 tb/tb_onchip_mem_stream_reader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_stream_reader_if
// Description : Bundle for the stream reader: command/status, on-chip memory
//               master port, and stream source with ready/valid.
// Revision    : 1.0 - initial release
// ============================================================================
interface onchip_mem_stream_reader_if #(
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 16
);
    // Command / status
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              busy;
    logic              done;

    // Memory master port
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic              m_clken;
    logic [31:0]       m_readdata;

    // Stream source
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready;

    // Reader side
    modport master (
        input  start, base_addr, word_count, m_readdata, out_ready,
        output busy, done, m_address, m_chipselect, m_write, m_byteenable,
               m_clken, out_data, out_valid
    );

    // Environment side (memory, CPU and stream consumer)
    modport slave (
        output start, base_addr, word_count, m_readdata, out_ready,
        input  busy, done, m_address, m_chipselect, m_write, m_byteenable,
               m_clken, out_data, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/onchip_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_stream_reader
// Description : Reads a contiguous block of words from a 1-cycle-latency
//               on-chip memory and streams them out in address order through
//               a small FIFO, throttling reads so backpressure loses nothing.
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_stream_reader #(
    parameter int ADDR_W     = 15,
    parameter int MEM_WORDS  = 32000,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    onchip_mem_stream_reader_if.master bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int PND_W = OCC_W + 2;

    localparam logic [PND_W-1:0]  PEND_LIMIT = PND_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_WORDS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              cs_q, cs_d;          // read being presented this cycle
    logic              rv1_q;               // read whose data is on m_readdata now
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;        // words not yet scheduled for reading
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [31:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic              w_push;
    logic              w_pop;
    logic              w_room;
    logic [PND_W-1:0]  w_pending;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_push     = rv1_q;
    assign w_pop      = (occ_q != '0) && bus.out_ready;
    // Buffered words plus reads still in the pipe must leave a slot free.
    assign w_pending  = PND_W'(occ_q) + PND_W'(cs_q) + PND_W'(rv1_q);
    assign w_room     = (w_pending < PEND_LIMIT);
    assign w_addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        occ_d = occ_q;
        case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; DRAIN ends once the FIFO will be empty and no read is left
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = (bus.word_count != '0) ? S_RUN : S_DONE;
            S_RUN:   if (rem_q == '0) state_d = S_DRAIN;
            S_DRAIN: if ((occ_d == '0) && !cs_q && !rv1_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values: read issue, address walk, status flags
    always_comb begin
        cs_d   = 1'b0;
        rem_d  = rem_q;
        addr_d = cs_q ? w_addr_inc : addr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.word_count != '0)) begin
                    cs_d   = 1'b1;
                    addr_d = bus.base_addr;
                    rem_d  = bus.word_count - CNT_W'(1);
                end
            end
            S_RUN: begin
                if ((rem_q != '0) && w_room) begin
                    cs_d  = 1'b1;
                    rem_d = rem_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DONE);
    end

    // Registered master outputs, return-path flag and status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q   <= 1'b0;
            rv1_q  <= 1'b0;
            addr_q <= '0;
            rem_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cs_q   <= cs_d;
            rv1_q  <= cs_q;
            addr_q <= addr_d;
            rem_q  <= rem_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (w_push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            occ_q <= occ_d;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) fifo_mem_q[wr_ptr_q] <= bus.m_readdata;
    end

    assign bus.m_address    = addr_q;
    assign bus.m_chipselect = cs_q;
    assign bus.m_write      = 1'b0;
    assign bus.m_byteenable = 4'hF;
    assign bus.m_clken      = 1'b1;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.out_valid    = (occ_q != '0);
    assign bus.out_data     = fifo_mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_onchip_mem_stream_reader
// Description : Directed bench with a queue-based model of the address and
//               data sequences expected from each transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_stream_reader;

    localparam int ADDR_W    = 15;
    localparam int MEM_WORDS = 32000;
    localparam int CNT_W     = 16;

    logic clk;
    logic reset_n;

    onchip_mem_stream_reader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus_if ();

    onchip_mem_stream_reader #(
        .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .CNT_W(CNT_W), .FIFO_DEPTH(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: word[a] = a, address registered, data one cycle later
    logic [31:0]       mem [MEM_WORDS];
    logic [ADDR_W-1:0] raddr;
    initial begin
        for (int a = 0; a < MEM_WORDS; a++) mem[a] = a;
        raddr = '0;
    end
    always @(posedge clk) if (bus_if.m_chipselect && bus_if.m_clken) raddr <= bus_if.m_address;
    assign bus_if.m_readdata = mem[raddr];

    // Expected read addresses and stream words of the active transfer
    int exp_addr[$];
    int exp_data[$];

    task automatic model_xfer(input int base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int a;
            a = (base + i) % MEM_WORDS;
            exp_addr.push_back(a);
            exp_data.push_back(a);
        end
    endtask

    // Every issued read and every accepted word must match the model in order
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus_if.m_chipselect) begin
                if (exp_addr.size() == 0) chk("extra_read_addr", bus_if.m_address, -1);
                else                      chk("read_addr", bus_if.m_address, exp_addr.pop_front());
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (exp_data.size() == 0) chk("extra_stream_word", bus_if.out_data, -1);
                else                      chk("stream_word", bus_if.out_data, exp_data.pop_front());
            end
        end
    end

    // Issue a one-cycle start; returns 1 time unit after the sampling edge E0
    task automatic do_start(input int base, input int cnt);
        @(posedge clk); #1;
        bus_if.start      = 1'b1;
        bus_if.base_addr  = ADDR_W'(base);
        bus_if.word_count = CNT_W'(cnt);
        @(posedge clk); #1;
        bus_if.start = 1'b0;
    endtask

    // Observe cycles j = 0..maxc-1 after E0; ready low for the first rl cycles,
    // optional stray start at cycle rsj
    task automatic watch(input int maxc, input int rl, input int rsj,
                         output int fv, output int lv, output int fd, output int dn,
                         output int nv, output int ncs, output int ncs_early, output int busy0);
        fv = -1; lv = -1; fd = -1; dn = 0; nv = 0; ncs = 0; ncs_early = 0; busy0 = 0;
        for (int j = 0; j < maxc; j++) begin
            bus_if.out_ready = (j >= rl);
            if (j == rsj) begin
                bus_if.start      = 1'b1;
                bus_if.base_addr  = ADDR_W'(5);
                bus_if.word_count = CNT_W'(2);
            end else begin
                bus_if.start = 1'b0;
            end
            @(negedge clk);
            if (j == 0) busy0 = bus_if.busy;
            if (bus_if.out_valid && fv < 0) fv = j;
            if (bus_if.out_valid && bus_if.out_ready) begin nv++; lv = j; end
            if (bus_if.m_chipselect) begin ncs++; if (j < rl) ncs_early++; end
            if (bus_if.done) begin dn++; if (fd < 0) fd = j; end
            @(posedge clk); #1;
        end
        bus_if.out_ready = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  bus_if.busy, 0);
        chk({tag, "_done"},  bus_if.done, 0);
        chk({tag, "_cs"},    bus_if.m_chipselect, 0);
        chk({tag, "_valid"}, bus_if.out_valid, 0);
        chk({tag, "_addr"},  bus_if.m_address, 0);
        chk({tag, "_write"}, bus_if.m_write, 0);
        chk({tag, "_be"},    bus_if.m_byteenable, 15);
        chk({tag, "_clken"}, bus_if.m_clken, 1);
    endtask

    int fv, lv, fd, dn, nv, ncs, ncse, b0;

    initial begin
        reset_n           = 1'b0;
        bus_if.start      = 1'b0;
        bus_if.base_addr  = '0;
        bus_if.word_count = '0;
        bus_if.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        reset_n = 1'b1;

        // Basic transfer: 100..107 at full rate
        model_xfer(100, 8);
        do_start(100, 8);
        watch(40, 0, -1, fv, lv, fd, dn, nv, ncs, ncse, b0);
        chk("t1_busy_after_start", b0, 1);
        chk("t1_first_valid", fv, 2);
        chk("t1_last_accept", lv, 9);
        chk("t1_done_cycle", fd, 11);
        chk("t1_done_pulses", dn, 1);
        chk("t1_words", nv, 8);
        chk("t1_reads", ncs, 8);
        chk("t1_model_empty", exp_data.size() + exp_addr.size(), 0);

        // Address wrap at the top of memory
        model_xfer(31998, 4);
        do_start(31998, 4);
        watch(30, 0, -1, fv, lv, fd, dn, nv, ncs, ncse, b0);
        chk("t2_first_valid", fv, 2);
        chk("t2_done_cycle", fd, 7);
        chk("t2_words", nv, 4);
        chk("t2_done_pulses", dn, 1);
        chk("t2_model_empty", exp_data.size() + exp_addr.size(), 0);

        // Backpressure: 10 stalled cycles cap reads at the FIFO depth
        model_xfer(100, 8);
        do_start(100, 8);
        watch(50, 10, -1, fv, lv, fd, dn, nv, ncs, ncse, b0);
        chk("t3_reads_while_stalled", ncse, 4);
        chk("t3_first_valid", fv, 2);
        chk("t3_words", nv, 8);
        chk("t3_reads", ncs, 8);
        chk("t3_done_pulses", dn, 1);
        chk("t3_model_empty", exp_data.size() + exp_addr.size(), 0);

        // Zero-length transfer
        do_start(200, 0);
        watch(10, 0, -1, fv, lv, fd, dn, nv, ncs, ncse, b0);
        chk("t4_busy_after_start", b0, 1);
        chk("t4_done_cycle", fd, 1);
        chk("t4_done_pulses", dn, 1);
        chk("t4_reads", ncs, 0);
        chk("t4_first_valid", fv, -1);

        // Reset after three accepted words
        model_xfer(100, 8);
        do_start(100, 8);
        nv = 0;
        for (int j = 0; j < 20 && nv < 3; j++) begin
            @(negedge clk);
            if (bus_if.out_valid && bus_if.out_ready) nv++;
            if (nv < 3) begin @(posedge clk); #1; end
        end
        chk("t5_accepted_before_reset", nv, 3);
        @(posedge clk); #1;
        reset_n = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        #1;
        chk_reset_outputs("t5_mid");
        @(posedge clk); #1;
        reset_n = 1'b1;
        watch(8, 0, -1, fv, lv, fd, dn, nv, ncs, ncse, b0);
        chk("t5_no_done", dn, 0);
        chk("t5_no_valid", fv, -1);
        model_xfer(0, 2);
        do_start(0, 2);
        watch(20, 0, -1, fv, lv, fd, dn, nv, ncs, ncse, b0);
        chk("t5b_first_valid", fv, 2);
        chk("t5b_done_cycle", fd, 5);
        chk("t5b_words", nv, 2);
        chk("t5b_model_empty", exp_data.size() + exp_addr.size(), 0);

        // Stray start while busy must not disturb the transfer
        model_xfer(100, 8);
        do_start(100, 8);
        watch(40, 0, 3, fv, lv, fd, dn, nv, ncs, ncse, b0);
        chk("t6_done_cycle", fd, 11);
        chk("t6_done_pulses", dn, 1);
        chk("t6_words", nv, 8);
        chk("t6_reads", ncs, 8);
        chk("t6_model_empty", exp_data.size() + exp_addr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
